// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// core_sequencer
//   Multi-cycle RV32I control FSM. It owns the single shared memory port and
//   drives the IR, PC and register-file write enables.
// Revision: 1.0  initial release
// ============================================================================
module core_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int INSTRET_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 is_system,
    input  logic                 is_illegal,
    input  logic                 writes_rd,
    input  logic                 rd_zero,
    input  logic                 mem_ready,
    input  logic                 resume,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 rf_we,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [7:0] C_TMO_LIMIT   = 8'(MEM_TIMEOUT);
    localparam logic [1:0] C_CAUSE_SYS   = 2'b00;
    localparam logic [1:0] C_CAUSE_ILL   = 2'b01;
    localparam logic [1:0] C_CAUSE_BUS   = 2'b10;

    state_t                 r_state;
    logic [7:0]             r_tmo;
    logic [1:0]             r_cause;
    logic [INSTRET_W-1:0]   r_instret;

    logic                   w_wait;
    logic                   w_timeout;
    logic                   w_retire;

    assign state      = r_state;
    assign halt_cause = r_cause;
    assign instret    = r_instret;

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        rf_we        = 1'b0;
        halted       = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_we       = is_store;
                mem_addr_sel = 1'b1;
                pc_we        = mem_ready & is_store;
                w_retire     = mem_ready & is_store;
            end
            S_WB: begin
                rf_we    = writes_rd & ~rd_zero;
                pc_we    = 1'b1;
                w_retire = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
                // Only ecall/ebreak steps past the halting instruction.
                pc_we  = resume & (r_cause == C_CAUSE_SYS);
            end
            default: ;
        endcase
    end

    // A completion arriving on the limit cycle beats the timeout.
    assign w_wait    = mem_req & ~mem_ready;
    assign w_timeout = w_wait & (r_tmo == C_TMO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_tmo     <= 8'd0;
            r_cause   <= C_CAUSE_SYS;
            r_instret <= '0;
        end else begin
            r_tmo <= (w_wait && !w_timeout) ? r_tmo + 8'd1 : 8'd0;

            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end

            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state <= S_HALT;
                        r_cause <= C_CAUSE_BUS;
                    end
                end
                S_DECODE: r_state <= S_EXEC;
                S_EXEC: begin
                    if (is_illegal) begin
                        r_state <= S_HALT;
                        r_cause <= C_CAUSE_ILL;
                    end else if (is_system) begin
                        r_state <= S_HALT;
                        r_cause <= C_CAUSE_SYS;
                    end else if (is_load || is_store) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        r_state <= is_store ? S_FETCH : S_WB;
                    end else if (w_timeout) begin
                        r_state <= S_HALT;
                        r_cause <= C_CAUSE_BUS;
                    end
                end
                S_WB:   r_state <= S_FETCH;
                S_HALT: begin
                    if (resume) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// tb_core_sequencer
//   Directed bench for core_sequencer with hand-computed expectations.
// Revision: 1.0  initial release
// ============================================================================
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        is_load, is_store, is_system, is_illegal;
    logic        writes_rd, rd_zero, mem_ready, resume;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, halted;
    logic [1:0]  halt_cause;
    logic [2:0]  state;
    logic [15:0] instret;

    int n_total = 0;
    int n_bad   = 0;

    core_sequencer #(
        .MEM_TIMEOUT (4),
        .INSTRET_W   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .is_load      (is_load),
        .is_store     (is_store),
        .is_system    (is_system),
        .is_illegal   (is_illegal),
        .writes_rd    (writes_rd),
        .rd_zero      (rd_zero),
        .mem_ready    (mem_ready),
        .resume       (resume),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .halted       (halted),
        .halt_cause   (halt_cause),
        .state        (state),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Move to the middle of the next clock cycle (away from the rising edge).
    task automatic adv();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; resume = 1'b0; mem_ready = 1'b1;
        is_load = 1'b0; is_store = 1'b0; is_system = 1'b0; is_illegal = 1'b0;
        writes_rd = 1'b1; rd_zero = 1'b0;
        #12;
        check_eq("rst_state",   state, 0);
        check_eq("rst_instret", instret, 0);
        check_eq("rst_cause",   halt_cause, 0);
        check_eq("rst_memreq",  mem_req, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // ALU op: F,D,E,W
        check_eq("alu_f_state", state, 0);
        check_eq("alu_f_irwe",  ir_we, 1);
        check_eq("alu_f_asel",  mem_addr_sel, 0);
        adv();
        check_eq("alu_d_state", state, 1);
        check_eq("alu_d_req",   mem_req, 0);
        adv();
        check_eq("alu_e_state", state, 2);
        adv();
        check_eq("alu_w_state", state, 4);
        check_eq("alu_w_rfwe",  rf_we, 1);
        check_eq("alu_w_pcwe",  pc_we, 1);
        adv();
        check_eq("alu_done_state", state, 0);
        check_eq("alu_instret",    instret, 1);

        // Load, memory answers on the 4th MEM cycle
        is_load = 1'b1;
        adv();
        check_eq("ld_d_state", state, 1);
        adv();
        check_eq("ld_e_state", state, 2);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adv();
            if (i == 3) begin
                mem_ready = 1'b1;
                #1;
            end
            check_eq("ld_m_state", state, 3);
            check_eq("ld_m_req",   mem_req, 1);
            check_eq("ld_m_asel",  mem_addr_sel, 1);
            check_eq("ld_m_we",    mem_we, 0);
        end
        adv();
        check_eq("ld_w_state", state, 4);
        check_eq("ld_w_rfwe",  rf_we, 1);
        adv();
        check_eq("ld_instret", instret, 2);

        // Store, no stalls
        is_load = 1'b0; is_store = 1'b1; writes_rd = 1'b0;
        adv(); adv(); adv();
        check_eq("st_m_state", state, 3);
        check_eq("st_m_we",    mem_we, 1);
        check_eq("st_m_pcwe",  pc_we, 1);
        check_eq("st_m_rfwe",  rf_we, 0);
        adv();
        check_eq("st_next_state", state, 0);
        check_eq("st_instret",    instret, 3);

        // ALU op targeting x0
        is_store = 1'b0; writes_rd = 1'b1; rd_zero = 1'b1;
        adv(); adv(); adv();
        check_eq("x0_w_state", state, 4);
        check_eq("x0_w_rfwe",  rf_we, 0);
        check_eq("x0_w_pcwe",  pc_we, 1);
        adv();
        check_eq("x0_instret", instret, 4);

        // Illegal beats system; resume re-fetches the same PC
        is_illegal = 1'b1; is_system = 1'b1;
        adv(); adv(); adv();
        check_eq("ill_state",  state, 5);
        check_eq("ill_halted", halted, 1);
        check_eq("ill_cause",  halt_cause, 1);
        check_eq("ill_req",    mem_req, 0);
        is_illegal = 1'b0; is_system = 1'b0; resume = 1'b1;
        #1;
        check_eq("ill_res_pcwe", pc_we, 0);
        adv();
        resume = 1'b0;
        check_eq("ill_res_state", state, 0);
        check_eq("ill_instret",   instret, 4);

        // ecall/ebreak: resume steps the PC
        is_system = 1'b1;
        adv(); adv(); adv();
        check_eq("sys_state", state, 5);
        check_eq("sys_cause", halt_cause, 0);
        is_system = 1'b0; resume = 1'b1;
        #1;
        check_eq("sys_res_pcwe", pc_we, 1);
        adv();
        resume = 1'b0;
        check_eq("sys_res_state", state, 0);
        check_eq("sys_instret",   instret, 4);

        // Fetch timeout: halt after the 5th request cycle
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adv();
            check_eq("tmo_wait_state", state, 0);
            check_eq("tmo_wait_req",   mem_req, 1);
        end
        adv();
        check_eq("tmo_state", state, 5);
        check_eq("tmo_cause", halt_cause, 2);
        resume = 1'b1;
        #1;
        check_eq("tmo_res_pcwe", pc_we, 0);
        adv();
        resume = 1'b0;
        check_eq("tmo_res_state", state, 0);

        // Ready on the limit cycle wins over the timeout
        for (int i = 0; i < 4; i++) adv();
        mem_ready = 1'b1;
        #1;
        check_eq("race_irwe", ir_we, 1);
        adv();
        check_eq("race_state", state, 1);
        adv(); adv(); adv();
        check_eq("race_instret", instret, 5);

        // Reset in the middle of a load wait
        is_load = 1'b1;
        adv(); adv();
        mem_ready = 1'b0;
        adv(); adv();
        check_eq("mid_state", state, 3);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_state",   state, 0);
        check_eq("mid_rst_instret", instret, 0);
        check_eq("mid_rst_cause",   halt_cause, 0);
        check_eq("mid_rst_asel",    mem_addr_sel, 0);
        adv();
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
